// File: rtl/synthesizer_top.sv
// Polyphonic oscillator mixer: Avalon-MM note commands, one mixed 24-bit sample every SAMPLE_DIV clocks.
// Sample appears VOICES+1 cycles after the counter wraps; commands and reads never stall; the stream has no backpressure.
module synthesizer_top #(
  parameter int VOICES     = 8,
  parameter int SAMPLE_DIV = 1042
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               avs_s0_write,
  input  logic               avs_s0_read,
  input  logic [31:0]        avs_s0_writedata,
  output logic [31:0]        avs_s0_readdata,
  output logic               o_dac_out,
  output logic [31:0]        aso_ss0_data,
  output logic               aso_ss0_valid,
  output logic signed [23:0] current_out
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int VW = $clog2(VOICES);
  localparam logic signed [21:0] AMP = 22'sd1048575;

  typedef enum logic [1:0] {WAVE_SINE, WAVE_SQUARE, WAVE_SAW, WAVE_TRI} wave_t;

  // Tuning words are elaboration-time constants; the real math never reaches hardware.
  function automatic logic [31:0] calc_tw(input int n);
    real         fs, f, base;
    logic [31:0] b;
    fs   = 100.0e6 / SAMPLE_DIV;
    f    = 440.0 * (2.0 ** ((real'(120 + (n % 12)) - 69.0) / 12.0));
    base = f * 4294967296.0 / fs;
    b    = 32'(longint'(base));
    return b >> (10 - (n / 12));
  endfunction

  function automatic logic signed [21:0] wave_val(input logic [31:0] ph, input wave_t w);
    logic [15:0]        p;
    logic [14:0]        x, u;
    logic [30:0]        prod;
    logic [22:0]        shr;
    logic [20:0]        m;
    logic signed [21:0] r;
    p    = ph[31:16];
    x    = p[14:0];
    u    = p[15] ? ~x : x;
    prod = {16'b0, x} * {15'b0, 16'd32768 - {1'b0, x}};
    shr  = prod[30:8];
    m    = (shr > 23'd1048575) ? 21'h0FFFFF : shr[20:0];
    case (w)
      WAVE_SQUARE: r = p[15] ? -AMP : AMP;
      WAVE_SAW:    r = $signed({~p[15], ~p[15], p[14:0], 5'b0});
      WAVE_TRI:    r = $signed({1'b0, u, 6'b0}) - 22'sd1048576;
      default:     r = p[15] ? -$signed({1'b0, m}) : $signed({1'b0, m});
    endcase
    return r;
  endfunction

  function automatic logic signed [23:0] sat24(input logic signed [27:0] v);
    if (v > 28'sd8388607)       return 24'sh7FFFFF;
    else if (v < -28'sd8388608) return 24'sh800000;
    else                        return v[23:0];
  endfunction

  logic [31:0] tw_rom [128];
  for (genvar g = 0; g < 128; g++) begin : g_rom
    localparam logic [31:0] TW = calc_tw(g);
    assign tw_rom[g] = TW;
  end

  logic [VOICES-1:0]  active;
  logic [6:0]         note  [VOICES];
  logic [31:0]        phase [VOICES];
  wave_t              wave;
  logic [CW-1:0]      cnt;
  logic signed [27:0] mix;
  logic [24:0]        dac_acc;

  logic               cmd_on;
  logic [6:0]         cmd_note;
  logic [VOICES-1:0]  hit_vec;
  logic               any_free;
  logic [VW-1:0]      free_idx;
  logic               in_slot;
  logic [VW-1:0]      vidx;
  logic signed [21:0] vsample;
  logic [31:0]        status;
  logic               unused_wd;

  assign cmd_on    = avs_s0_writedata[15];
  assign cmd_note  = avs_s0_writedata[14:8];
  assign unused_wd = ^{avs_s0_writedata[31:16], avs_s0_writedata[7:0]};
  assign in_slot   = (cnt != '0) && (cnt <= CW'(VOICES));
  assign vidx      = VW'(cnt - 1'b1);
  assign vsample   = wave_val(phase[vidx], wave);

  // Lowest free voice wins because the scan runs downward.
  always_comb begin
    hit_vec  = '0;
    any_free = 1'b0;
    free_idx = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      hit_vec[i] = active[i] && (note[i] == cmd_note);
      if (!active[i]) begin
        any_free = 1'b1;
        free_idx = VW'(i);
      end
    end
  end

  always_comb begin
    status               = '0;
    status[VOICES-1:0]   = active;
    status[17:16]        = wave;
  end

  // Commands are applied after the slot update so they take effect immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active          <= '0;
      for (int i = 0; i < VOICES; i++) begin
        note[i]  <= '0;
        phase[i] <= '0;
      end
      wave            <= WAVE_SINE;
      cnt             <= '0;
      mix             <= '0;
      current_out     <= '0;
      aso_ss0_valid   <= 1'b0;
      avs_s0_readdata <= '0;
    end else begin
      aso_ss0_valid <= 1'b0;
      cnt <= (cnt == CW'(SAMPLE_DIV - 1)) ? '0 : cnt + 1'b1;
      if (cnt == '0) begin
        mix <= '0;
      end else if (in_slot) begin
        if (active[vidx]) begin
          mix         <= mix + {{6{vsample[21]}}, vsample};
          phase[vidx] <= phase[vidx] + tw_rom[note[vidx]];
        end
      end else if (cnt == CW'(VOICES + 1)) begin
        current_out   <= sat24(mix);
        aso_ss0_valid <= 1'b1;
      end

      if (avs_s0_read) avs_s0_readdata <= status;

      if (avs_s0_write) begin
        if (cmd_on) begin
          if (cmd_note == 7'd0) begin
            wave <= wave_t'(wave + 2'd1);
          end else if ((hit_vec == '0) && any_free) begin
            active[free_idx] <= 1'b1;
            note[free_idx]   <= cmd_note;
            phase[free_idx]  <= '0;
          end
        end else if (cmd_note == 7'd127) begin
          active <= '0;
        end else if (cmd_note != 7'd0) begin
          active <= active & ~hit_vec;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dac_acc <= '0;
    else       dac_acc <= {1'b0, dac_acc[23:0]} + {1'b0, current_out ^ 24'h800000};
  end

  assign o_dac_out    = dac_acc[24];
  assign aso_ss0_data = {{8{current_out[23]}}, current_out};

endmodule

// File: tb/tb_synthesizer_top.sv
// Scoreboard bench for synthesizer_top: reference model predicts each mixed sample and status word.
module tb_synthesizer_top;
  localparam int NV   = 8;
  localparam int SDIV = 32;
  localparam int AMAX = 1048575;

  logic               clk = 1'b0;
  logic               reset;
  logic               avs_s0_write;
  logic               avs_s0_read;
  logic [31:0]        avs_s0_writedata;
  logic [31:0]        avs_s0_readdata;
  logic               o_dac_out;
  logic [31:0]        aso_ss0_data;
  logic               aso_ss0_valid;
  logic signed [23:0] current_out;

  synthesizer_top #(.VOICES(NV), .SAMPLE_DIV(SDIV)) dut (
    .clk              (clk),
    .reset            (reset),
    .avs_s0_write     (avs_s0_write),
    .avs_s0_read      (avs_s0_read),
    .avs_s0_writedata (avs_s0_writedata),
    .avs_s0_readdata  (avs_s0_readdata),
    .o_dac_out        (o_dac_out),
    .aso_ss0_data     (aso_ss0_data),
    .aso_ss0_valid    (aso_ss0_valid),
    .current_out      (current_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_valid = -1;
  int peak = 0;
  longint sb_q[$];
  longint rd_q[$];

  bit        m_act  [NV];
  int        m_note [NV];
  bit [31:0] m_phase[NV];
  int        m_wave;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] tw_ref(input int n);
    real fs, f, b;
    bit [31:0] base;
    fs   = 100.0e6 / SDIV;
    f    = 440.0 * (2.0 ** ((120.0 + (n % 12) - 69.0) / 12.0));
    b    = f * 4294967296.0 / fs;
    base = 32'(longint'($floor(b + 0.5)));
    return base >> (10 - n / 12);
  endfunction

  function automatic int wave_ref(input bit [31:0] ph, input int w);
    int p, x, u, m;
    p = int'(ph[31:16]);
    x = p % 32768;
    case (w)
      1: return (p < 32768) ? AMAX : -AMAX;
      2: return (p - 32768) * 32;
      3: begin
        u = (p >= 32768) ? (32767 - x) : x;
        return u * 64 - 1048576;
      end
      default: begin
        m = (x * (32768 - x)) / 256;
        if (m > AMAX) m = AMAX;
        return (p >= 32768) ? -m : m;
      end
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_act[i] = 0; m_note[i] = 0; m_phase[i] = 0;
    end
    m_wave = 0;
  endfunction

  function automatic void model_cmd(input logic [15:0] w);
    int n;
    bit found;
    n = int'(w[14:8]);
    found = 0;
    if (w[15]) begin
      if (n == 0) m_wave = (m_wave + 1) % 4;
      else begin
        for (int i = 0; i < NV; i++) if (m_act[i] && m_note[i] == n) found = 1;
        if (!found) begin
          for (int i = 0; i < NV; i++) begin
            if (!m_act[i]) begin
              m_act[i] = 1; m_note[i] = n; m_phase[i] = 0;
              break;
            end
          end
        end
      end
    end else if (n == 127) begin
      for (int i = 0; i < NV; i++) m_act[i] = 0;
    end else if (n != 0) begin
      for (int i = 0; i < NV; i++) if (m_act[i] && m_note[i] == n) m_act[i] = 0;
    end
  endfunction

  function automatic longint model_sample();
    longint s;
    s = 0;
    for (int i = 0; i < NV; i++) begin
      if (m_act[i]) begin
        s += wave_ref(m_phase[i], m_wave);
        m_phase[i] += tw_ref(m_note[i]);
      end
    end
    if (s > 8388607)  s = 8388607;
    if (s < -8388608) s = -8388608;
    return s;
  endfunction

  function automatic longint model_status();
    longint r;
    r = longint'(m_wave) << 16;
    for (int i = 0; i < NV; i++) if (m_act[i]) r |= (longint'(1) << i);
    return r;
  endfunction

  // Caller is at a negedge, outside the voice-processing window.
  task automatic cmd(input logic [15:0] w);
    avs_s0_writedata = {16'hA5C3, w};
    avs_s0_write     = 1'b1;
    @(negedge clk);
    avs_s0_write     = 1'b0;
    avs_s0_writedata = 32'h0;
    model_cmd(w);
  endtask

  task automatic read_chk(input string tag);
    rd_q.push_back(model_status());
    avs_s0_read = 1'b1;
    @(negedge clk);
    avs_s0_read = 1'b0;
    check_val(tag, {32'b0, avs_s0_readdata}, rd_q.pop_front());
  endtask

  task automatic wait_sample(input string tag);
    bit got;
    longint e;
    logic [31:0] ed;
    sb_q.push_back(model_sample());
    got = 0;
    for (int i = 0; i < 4 * SDIV && !got; i++) begin
      @(negedge clk);
      if (aso_ss0_valid) got = 1;
    end
    check_val({tag, "_valid_seen"}, 64'(got), 64'd1);
    e = sb_q.pop_front();
    if (got) begin
      check_val({tag, "_sample"}, 64'(current_out), e);
      ed = 32'(e);
      check_val({tag, "_aso_data"}, {32'b0, aso_ss0_data}, {32'b0, ed});
      if (last_valid >= 0) check_val({tag, "_period"}, 64'(cyc - last_valid), 64'(SDIV));
      last_valid = cyc;
      if ((current_out < 0 ? -int'(current_out) : int'(current_out)) > peak)
        peak = (current_out < 0) ? -int'(current_out) : int'(current_out);
      @(negedge clk);
      check_val({tag, "_valid_one_cycle"}, 64'(aso_ss0_valid), 64'd0);
    end
  endtask

  task automatic run_samples(input string tag, input int n);
    for (int i = 0; i < n; i++) wait_sample(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ones;
    reset = 1'b0; avs_s0_write = 1'b0; avs_s0_read = 1'b0; avs_s0_writedata = 32'h0;
    model_reset();
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_current_out", 64'(current_out), 64'd0);
    check_val("rst_valid", 64'(aso_ss0_valid), 64'd0);
    check_val("rst_readdata", {32'b0, avs_s0_readdata}, 64'd0);
    check_val("rst_dac", 64'(o_dac_out), 64'd0);
    reset = 1'b0;

    read_chk("idle_status");
    ones = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ones += int'(o_dac_out);
    end
    check_val("dac_duty_idle", 64'(ones), 64'd50);
    run_samples("idle", 3);

    cmd(16'hC500);
    read_chk("mask_a4");
    peak = 0;
    run_samples("a4_sine", 12);
    cmd(16'hFF00);
    read_chk("mask_a4_g9");
    run_samples("two_sines", 12);
    check_val("sine_peak_le_A", 64'(peak <= AMAX), 64'd1);

    cmd(16'h8000);
    read_chk("wave_square");
    run_samples("square", 10);
    cmd(16'h8000);
    read_chk("wave_saw");
    run_samples("saw", 10);
    cmd(16'h8000);
    read_chk("wave_tri");
    run_samples("tri", 10);
    cmd(16'h8000);
    read_chk("wave_sine_again");
    run_samples("sine2", 4);

    cmd(16'h7F00);
    read_chk("stop_all_1");
    run_samples("silent1", 2);

    cmd(16'hC500); cmd(16'hC500); cmd(16'hA800); cmd(16'hBC00); cmd(16'hCD00); cmd(16'hDF00);
    read_chk("mask_1f");
    run_samples("five_voices", 6);
    cmd(16'h4A00);
    read_chk("off_unplayed");
    cmd(16'h0000);
    read_chk("off_note0");
    cmd(16'h4500);
    read_chk("off_a4_mask_1e");
    run_samples("four_voices", 6);

    cmd(16'hE400); cmd(16'hE500); cmd(16'hE600); cmd(16'hE700); cmd(16'hE800);
    read_chk("mask_full");
    run_samples("full", 6);
    cmd(16'h7F00);
    read_chk("stop_all_2");
    run_samples("silent2", 2);

    cmd(16'h8000);
    cmd(16'hC500);
    read_chk("pre_reset_mask");
    run_samples("pre_reset", 3);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("midrst_current_out", 64'(current_out), 64'd0);
    check_val("midrst_aso_data", {32'b0, aso_ss0_data}, 64'd0);
    check_val("midrst_valid", 64'(aso_ss0_valid), 64'd0);
    check_val("midrst_readdata", {32'b0, avs_s0_readdata}, 64'd0);
    check_val("midrst_dac", 64'(o_dac_out), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    last_valid = -1;
    read_chk("post_reset_mask");
    run_samples("post_reset", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
